// File: rtl/sm4_key_scheduler_pkg.sv
// Shared SM4 key-expansion definitions: FK constants, round count,
// CK generation steps, FSM state type, S-box and CK helper.
package sm4_pkg;

   localparam int SM4_ROUNDS     = 32;
   localparam int CK_STEP_ROUND  = 28;
   localparam int CK_STEP_BYTE   = 7;

   localparam logic [31:0] FK0 = 32'hA3B1BAC6;
   localparam logic [31:0] FK1 = 32'h56AA3350;
   localparam logic [31:0] FK2 = 32'h677D9197;
   localparam logic [31:0] FK3 = 32'hB27022DC;
   localparam logic [127:0] FK_ALL = {FK0, FK1, FK2, FK3};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sm4_state_e;

   // Element 0 sits in the most significant byte.
   localparam logic [0:255][7:0] SBOX = {
      128'hd690e9fecce13db716b614c228fb2c05,
      128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62,
      128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8,
      128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887,
      128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1,
      128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f,
      128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8,
      128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684,
      128'h18f07dec3adc4d2079ee5f3ed7cb3948
   };

   function automatic logic [7:0] sm4_sbox(input logic [7:0] x);
      return SBOX[x];
   endfunction

   // CK byte j of round i is (28*i + 7*j) mod 256, byte 0 in the MSBs.
   function automatic logic [31:0] ck_gen(input logic [4:0] i);
      logic [7:0] base;
      base = 8'(int'(i) * CK_STEP_ROUND);
      return {base,
              base + 8'(CK_STEP_BYTE),
              base + 8'(2 * CK_STEP_BYTE),
              base + 8'(3 * CK_STEP_BYTE)};
   endfunction

endpackage

// File: rtl/sm4_key_scheduler_if.sv
// Key scheduler bus: key start handshake, clear, round-key stream and
// key-store read port. The scheduler is the slave side.
interface sm4_key_scheduler_if;
   logic [127:0] key_in;
   logic         key_valid_in;
   logic         key_ready_out;
   logic         clear_in;
   logic [31:0]  rk_out;
   logic [4:0]   rk_index_out;
   logic         rk_valid_out;
   logic         done_out;
   logic         keys_valid_out;
   logic [4:0]   rd_addr_in;
   logic [31:0]  rd_data_out;

   modport master (
      output key_in, key_valid_in, clear_in, rd_addr_in,
      input  key_ready_out, rk_out, rk_index_out, rk_valid_out,
             done_out, keys_valid_out, rd_data_out
   );

   modport slave (
      input  key_in, key_valid_in, clear_in, rd_addr_in,
      output key_ready_out, rk_out, rk_index_out, rk_valid_out,
             done_out, keys_valid_out, rd_data_out
   );
endinterface

// File: rtl/sm4_key_scheduler_round.sv
// One SM4 key-expansion round: K(i+4) = K(i) ^ T'(K(i+1)^K(i+2)^K(i+3)^CK(i)).
// FK whitening is folded in on the first round so the state register can
// be loaded directly with the raw user key.
module one_round_for_key_exp
   import sm4_pkg::*;
(
   input  logic         count_round_in,
   input  logic [127:0] data_in,
   input  logic [31:0]  ck_parameter_in,
   output logic [127:0] result_out
);

   logic [127:0] w_k;
   logic [31:0]  w_x;
   logic [31:0]  w_b;
   logic [31:0]  w_l;

   assign w_k = count_round_in ? (data_in ^ FK_ALL) : data_in;
   assign w_x = w_k[95:64] ^ w_k[63:32] ^ w_k[31:0] ^ ck_parameter_in;

   assign w_b = {sm4_sbox(w_x[31:24]), sm4_sbox(w_x[23:16]),
                 sm4_sbox(w_x[15:8]),  sm4_sbox(w_x[7:0])};

   // L' = B ^ (B <<< 13) ^ (B <<< 23)
   assign w_l = w_b ^ {w_b[18:0], w_b[31:19]} ^ {w_b[8:0], w_b[31:9]};

   assign result_out = {w_k[95:0], w_k[127:96] ^ w_l};

endmodule

// File: rtl/sm4_key_scheduler.sv
// SM4 key scheduler: accepts a 128-bit user key and streams the 32 round
// keys, one per cycle, with index, done pulse and a held "keys valid" flag.
// Optional key store enabled by defining SM4_KEY_STORE_EN.
//
// state | meaning
// IDLE  | waiting for a start, ready high
// RUN   | one round key produced per cycle, ready low
// DONE  | all 32 keys produced, ready high for a new start
module sm4_key_scheduler
   import sm4_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset_n,
   sm4_key_scheduler_if.slave     bus
);

   sm4_state_e   r_state;
   logic [4:0]   r_cnt;
   logic [127:0] r_key;
   logic [31:0]  r_rk;
   logic [4:0]   r_idx;
   logic         r_valid;
   logic         r_done;
   logic         r_keys_valid;
   logic         r_ready;

   logic [31:0]  w_ck;
   logic         w_first;
   logic [127:0] w_round;
   logic         w_start;

   assign w_ck    = ck_gen(r_cnt);
   assign w_first = (r_cnt == 5'd0);
   assign w_start = bus.key_valid_in && r_ready && !bus.clear_in;

   one_round_for_key_exp u_round (
      .count_round_in  (w_first),
      .data_in         (r_key),
      .ck_parameter_in (w_ck),
      .result_out      (w_round)
   );

   // Sequencing FSM with registered stream outputs; clear overrides everything.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 5'd0;
         r_key        <= '0;
         r_rk         <= '0;
         r_idx        <= 5'd0;
         r_valid      <= 1'b0;
         r_done       <= 1'b0;
         r_keys_valid <= 1'b0;
         r_ready      <= 1'b1;
      end else if (bus.clear_in) begin
         r_state      <= ST_IDLE;
         r_valid      <= 1'b0;
         r_done       <= 1'b0;
         r_keys_valid <= 1'b0;
         r_ready      <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               r_valid <= 1'b0;
               r_done  <= 1'b0;
               if (r_done) r_keys_valid <= 1'b1;
               if (w_start) begin
                  r_state      <= ST_RUN;
                  r_key        <= bus.key_in;
                  r_cnt        <= 5'd0;
                  r_keys_valid <= 1'b0;
                  r_ready      <= 1'b0;
               end
            end
            ST_RUN: begin
               r_key   <= w_round;
               r_rk    <= w_round[31:0];
               r_idx   <= r_cnt;
               r_valid <= 1'b1;
               r_cnt   <= r_cnt + 5'd1;
               if (r_cnt == 5'(SM4_ROUNDS - 1)) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_valid <= 1'b0;
               r_done  <= 1'b0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.key_ready_out  = r_ready;
   assign bus.rk_out         = r_rk;
   assign bus.rk_index_out   = r_idx;
   assign bus.rk_valid_out   = r_valid;
   assign bus.done_out       = r_done;
   assign bus.keys_valid_out = r_keys_valid;

`ifdef SM4_KEY_STORE_EN
   logic [31:0] r_store [SM4_ROUNDS];

   // Capture each streamed key at its index; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (r_valid) r_store[r_idx] <= r_rk;
   end

   assign bus.rd_data_out = r_store[bus.rd_addr_in];
`else
   logic w_unused_rd;
   assign w_unused_rd     = ^bus.rd_addr_in;
   assign bus.rd_data_out = 32'd0;
`endif

endmodule

// File: tb/tb_sm4_key_scheduler.sv
// Directed bench for sm4_key_scheduler: known-answer key, CK values,
// busy-start rejection, clear and async reset mid-run, key store read.
module tb_sm4_key_scheduler;

   localparam logic [127:0] KEY_A   = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] KEY_B   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [31:0]  RK0_A   = 32'hf12186f9;
   localparam logic [31:0]  RK31_A  = 32'h9124a012;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_err;

   sm4_key_scheduler_if ifc ();

   sm4_key_scheduler dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifc.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [127:0] k, input string tag);
      ifc.key_in       = k;
      ifc.key_valid_in = 1'b1;
      tick();
      ifc.key_valid_in = 1'b0;
      check({tag, "_ready_low"}, 32'(ifc.key_ready_out), 32'd0);
   endtask

   task automatic wait_idx(input logic [4:0] target, input string tag);
      bit found;
      found = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
         tick();
         if (ifc.rk_valid_out && ifc.rk_index_out == target) found = 1'b1;
      end
      check({tag, "_reach_idx"}, 32'(found), 32'd1);
   endtask

   task automatic collect(input bit hold_busy, input bit do_ck, input string tag);
      int nvalid, ndone;
      bit idx_ok, done31, fin;
      logic [31:0] rk0, rk31;
      nvalid = 0; ndone = 0; idx_ok = 1'b1; done31 = 1'b0; fin = 1'b0;
      rk0 = '0; rk31 = '0;
      check({tag, "_no_valid_first_cycle"}, 32'(ifc.rk_valid_out), 32'd0);
      if (do_ck) check("ck_round0", dut.w_ck, 32'h00070e15);
      if (hold_busy) begin
         ifc.key_in       = KEY_B;
         ifc.key_valid_in = 1'b1;
      end
      for (int c = 0; c < 40 && !fin; c++) begin
         tick();
         if (c == 5) check({tag, "_ready_in_run"}, 32'(ifc.key_ready_out), 32'd0);
         if (ifc.rk_valid_out) begin
            if (nvalid == 0 && c != 0) idx_ok = 1'b0;
            if (ifc.rk_index_out != 5'(nvalid)) idx_ok = 1'b0;
            if (ifc.done_out) done31 = (ifc.rk_index_out == 5'd31);
            if (ifc.rk_index_out == 5'd0) begin
               rk0 = ifc.rk_out;
               if (do_ck) check("ck_round1", dut.w_ck, 32'h1c232a31);
            end
            if (ifc.rk_index_out == 5'd30 && do_ck) check("ck_round31", dut.w_ck, 32'h646b7279);
            if (ifc.rk_index_out == 5'd31) begin
               rk31 = ifc.rk_out;
               if (hold_busy) ifc.key_valid_in = 1'b0;
            end
            nvalid++;
         end else if (nvalid > 0) begin
            fin = 1'b1;
            check({tag, "_keys_valid_set"}, 32'(ifc.keys_valid_out), 32'd1);
            check({tag, "_done_one_cycle"}, 32'(ifc.done_out), 32'd0);
            check({tag, "_ready_done"}, 32'(ifc.key_ready_out), 32'd1);
         end
         if (ifc.done_out) ndone++;
      end
      check({tag, "_finished"}, 32'(fin), 32'd1);
      check({tag, "_contig_count"}, 32'(nvalid), 32'd32);
      check({tag, "_index_latency"}, 32'(idx_ok), 32'd1);
      check({tag, "_done_count"}, 32'(ndone), 32'd1);
      check({tag, "_done_at_31"}, 32'(done31), 32'd1);
      check({tag, "_rk0"}, rk0, RK0_A);
      check({tag, "_rk31"}, rk31, RK31_A);
   endtask

   initial begin
      n_checks = 0;
      n_err    = 0;
      reset_n          = 1'b0;
      ifc.key_in       = '0;
      ifc.key_valid_in = 1'b0;
      ifc.clear_in     = 1'b0;
      ifc.rd_addr_in   = 5'd0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      check("rst_ready",      32'(ifc.key_ready_out),  32'd1);
      check("rst_valid",      32'(ifc.rk_valid_out),   32'd0);
      check("rst_rk",         ifc.rk_out,              32'd0);
      check("rst_idx",        32'(ifc.rk_index_out),   32'd0);
      check("rst_done",       32'(ifc.done_out),       32'd0);
      check("rst_keys_valid", 32'(ifc.keys_valid_out), 32'd0);

      // Known-answer run with CK probes.
      start(KEY_A, "run1");
      collect(1'b0, 1'b1, "run1");

      // Store readback (decrypt order addresses).
      ifc.rd_addr_in = 5'd0;
      #1;
`ifdef SM4_KEY_STORE_EN
      check("store_addr0", ifc.rd_data_out, RK0_A);
`else
      check("store_addr0", ifc.rd_data_out, 32'd0);
`endif
      ifc.rd_addr_in = 5'd31;
      #1;
`ifdef SM4_KEY_STORE_EN
      check("store_addr31", ifc.rd_data_out, RK31_A);
`else
      check("store_addr31", ifc.rd_data_out, 32'd0);
`endif
      tick();
      check("done_hold_keys_valid", 32'(ifc.keys_valid_out), 32'd1);

      // Start from DONE, with a different key held on the bus during RUN.
      start(KEY_A, "busy");
      check("busy_keys_valid_clr", 32'(ifc.keys_valid_out), 32'd0);
      collect(1'b1, 1'b0, "busy");

      // Clear at index 10, coincident with a start request.
      start(KEY_A, "clr");
      wait_idx(5'd10, "clr");
      ifc.clear_in     = 1'b1;
      ifc.key_in       = KEY_B;
      ifc.key_valid_in = 1'b1;
      tick();
      ifc.clear_in     = 1'b0;
      ifc.key_valid_in = 1'b0;
      check("clr_valid",      32'(ifc.rk_valid_out),   32'd0);
      check("clr_done",       32'(ifc.done_out),       32'd0);
      check("clr_keys_valid", 32'(ifc.keys_valid_out), 32'd0);
      check("clr_ready",      32'(ifc.key_ready_out),  32'd1);
      check("clr_idx_hold",   32'(ifc.rk_index_out),   32'd10);
      tick();
      check("clr_start_rejected", 32'(ifc.rk_valid_out), 32'd0);
      check("clr_still_idle",     32'(ifc.key_ready_out), 32'd1);
      start(KEY_A, "after_clr");
      collect(1'b0, 1'b0, "after_clr");

      // Asynchronous reset at index 20.
      start(KEY_A, "rst");
      wait_idx(5'd20, "rst");
      reset_n = 1'b0;
      #1;
      check("arst_rk",         ifc.rk_out,              32'd0);
      check("arst_idx",        32'(ifc.rk_index_out),   32'd0);
      check("arst_valid",      32'(ifc.rk_valid_out),   32'd0);
      check("arst_done",       32'(ifc.done_out),       32'd0);
      check("arst_keys_valid", 32'(ifc.keys_valid_out), 32'd0);
      check("arst_ready",      32'(ifc.key_ready_out),  32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("arst_no_more_valid", 32'(ifc.rk_valid_out), 32'd0);
      start(KEY_A, "after_rst");
      collect(1'b0, 1'b0, "after_rst");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
